// File: rtl/pattern_sequencer_if.sv
// Count/select bundle between the sync generator, the pattern sequencer and
// the pattern generator. The master side drives the counts; the sequencer is the slave.
interface pattern_sequencer_if;
    logic [9:0] i_Col_Count;
    logic [9:0] i_Row_Count;
    logic [3:0] o_Pattern;
    logic       o_Auto;
    logic       o_Frame_Start;

    modport master (
        output i_Col_Count,
        output i_Row_Count,
        input  o_Pattern,
        input  o_Auto,
        input  o_Frame_Start
    );

    modport slave (
        input  i_Col_Count,
        input  i_Row_Count,
        output o_Pattern,
        output o_Auto,
        output o_Frame_Start
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Pattern select controller: debounced Next/Mode switches, manual stepping and an
// auto slideshow. The pattern select changes only at a frame start.
//
// state     | meaning
// ST_MANUAL | pattern advances only on a pending Next press
// ST_AUTO   | pattern also advances every FRAMES_PER_PATTERN frame starts
module pattern_sequencer #(
    parameter int NUM_PATTERNS       = 7,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int DEBOUNCE_LIMIT     = 250000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Next_Sw,
    input  logic                 i_Mode_Sw,
    pattern_sequencer_if.slave   bus
);

    localparam int DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam int FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [DW-1:0] LP_DB_LAST    = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [FW-1:0] LP_FRAME_LAST = FW'(FRAMES_PER_PATTERN - 1);
    localparam logic [3:0]    LP_PAT_LAST   = 4'(NUM_PATTERNS - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          w_sw_raw;
    logic [1:0]          r_sw_meta;
    logic [1:0]          r_sw_sync;
    logic [1:0]          r_db;
    logic [1:0]          r_db_d;
    logic [1:0][DW-1:0]  r_db_cnt;
    logic                w_next_pulse;
    logic                w_mode_pulse;
    logic                w_frame_cond;
    logic                r_frame_cond_d;
    logic                w_frame_start;
    logic                r_frame_start;
    logic                r_step_pending;
    logic [FW-1:0]       r_frame_cnt;
    logic [3:0]          r_pattern;
    logic                w_advance;

    // Bit 0 is the Next switch, bit 1 the Mode switch.
    assign w_sw_raw = {i_Mode_Sw, i_Next_Sw};

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_db      <= '0;
            r_db_d    <= '0;
            r_db_cnt  <= '0;
        end else begin
            r_sw_meta <= w_sw_raw;
            r_sw_sync <= r_sw_meta;
            r_db_d    <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sw_sync[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == LP_DB_LAST) begin
                    r_db[i]     <= ~r_db[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_next_pulse  = r_db[0] & ~r_db_d[0];
    assign w_mode_pulse  = r_db[1] & ~r_db_d[1];

    // Counts held at zero for several clocks still give a single frame start.
    assign w_frame_cond  = (bus.i_Col_Count == 10'd0) && (bus.i_Row_Count == 10'd0);
    assign w_frame_start = w_frame_cond & ~r_frame_cond_d;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        if (w_mode_pulse) begin
            w_state_next = (r_state == ST_MANUAL) ? ST_AUTO : ST_MANUAL;
        end
        if (w_frame_start) begin
            w_advance = r_step_pending |
                        ((r_state == ST_AUTO) && (r_frame_cnt == LP_FRAME_LAST));
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_frame_cond_d <= 1'b0;
            r_frame_start  <= 1'b0;
            r_step_pending <= 1'b0;
            r_frame_cnt    <= '0;
            r_pattern      <= 4'd0;
        end else begin
            r_frame_cond_d <= w_frame_cond;
            r_frame_start  <= w_frame_start;

            // A press coinciding with a frame start is kept for the following frame.
            if (w_next_pulse) begin
                r_step_pending <= 1'b1;
            end else if (w_frame_start) begin
                r_step_pending <= 1'b0;
            end

            if (w_mode_pulse || (r_state == ST_MANUAL)) begin
                r_frame_cnt <= '0;
            end else if (w_frame_start) begin
                r_frame_cnt <= w_advance ? '0 : r_frame_cnt + FW'(1);
            end

            if (w_advance) begin
                r_pattern <= (r_pattern >= LP_PAT_LAST) ? 4'd1 : r_pattern + 4'd1;
            end
        end
    end

    assign bus.o_Pattern     = r_pattern;
    assign bus.o_Auto        = (r_state == ST_AUTO);
    assign bus.o_Frame_Start = r_frame_start;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: reset, debounce, manual wrap, auto
// slideshow, Next/auto coincidence and held-zero frame detection.
module tb_pattern_sequencer;

    logic clk;
    logic rst_l;
    logic next_sw;
    logic mode_sw;
    logic hold_zero;
    int   n_total;
    int   n_bad;

    logic [3:0] wrap_seq [7];
    logic [3:0] auto_seq [10];
    logic [3:0] p;
    int         n_fs;

    pattern_sequencer_if bus ();

    pattern_sequencer #(
        .NUM_PATTERNS       (7),
        .FRAMES_PER_PATTERN (3),
        .DEBOUNCE_LIMIT     (4)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_l),
        .i_Next_Sw (next_sw),
        .i_Mode_Sw (mode_sw),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: outputs are read 1 ns after the edge, counts advance 10x5 frame.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_zero) begin
            if (bus.i_Col_Count == 10'd9) begin
                bus.i_Col_Count = 10'd0;
                bus.i_Row_Count = (bus.i_Row_Count == 10'd4) ? 10'd0 : bus.i_Row_Count + 10'd1;
            end else begin
                bus.i_Col_Count = bus.i_Col_Count + 10'd1;
            end
        end
    endtask

    task automatic press(input bit is_mode);
        if (is_mode) mode_sw = 1'b1; else next_sw = 1'b1;
        repeat (10) tick();
        if (is_mode) mode_sw = 1'b0; else next_sw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic wait_fs(input string tag, input logic [3:0] exp_before, input logic [3:0] exp_after);
        int         n;
        logic [3:0] pb;
        n  = 0;
        pb = bus.o_Pattern;
        while (n < 200) begin
            pb = bus.o_Pattern;
            tick();
            n++;
            if (bus.o_Frame_Start === 1'b1) break;
        end
        if (bus.o_Frame_Start !== 1'b1) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_pre"}, {28'd0, pb}, {28'd0, exp_before});
            chk({tag, "_post"}, {28'd0, bus.o_Pattern}, {28'd0, exp_after});
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        hold_zero = 1'b0;
        rst_l     = 1'b0;
        next_sw   = 1'b0;
        mode_sw   = 1'b0;
        bus.i_Col_Count = 10'd3;
        bus.i_Row_Count = 10'd2;
        wrap_seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd2};
        auto_seq = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

        repeat (3) tick();
        chk("rst_pattern", {28'd0, bus.o_Pattern}, 32'd0);
        chk("rst_auto", {31'd0, bus.o_Auto}, 32'd0);
        chk("rst_fs", {31'd0, bus.o_Frame_Start}, 32'd0);
        rst_l = 1'b1;
        wait_fs("init", 4'd0, 4'd0);

        // Reset mid-frame with a step pending discards the step.
        press(1'b0);
        chk("pend_hold", {28'd0, bus.o_Pattern}, 32'd0);
        rst_l = 1'b0;
        repeat (3) tick();
        chk("mid_rst_pattern", {28'd0, bus.o_Pattern}, 32'd0);
        chk("mid_rst_auto", {31'd0, bus.o_Auto}, 32'd0);
        chk("mid_rst_fs", {31'd0, bus.o_Frame_Start}, 32'd0);
        rst_l = 1'b1;
        wait_fs("rst_nostep", 4'd0, 4'd0);

        // Bouncing Next: 2-clock toggles never settle, then a clean hold.
        for (int i = 0; i < 10; i++) begin
            next_sw = (i % 2 == 0);
            repeat (2) tick();
        end
        next_sw = 1'b1;
        repeat (8) tick();
        next_sw = 1'b0;
        repeat (8) tick();
        chk("deb_hold", {28'd0, bus.o_Pattern}, 32'd0);
        wait_fs("deb_step", 4'd0, 4'd1);
        wait_fs("deb_once", 4'd1, 4'd1);

        p = 4'd1;
        for (int k = 0; k < 7; k++) begin
            press(1'b0);
            chk("wrap_hold", {28'd0, bus.o_Pattern}, {28'd0, p});
            wait_fs("wrap", p, wrap_seq[k]);
            p = wrap_seq[k];
        end

        press(1'b1);
        chk("auto_on", {31'd0, bus.o_Auto}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            wait_fs("auto_f1", p, p);
            wait_fs("auto_f2", p, p);
            wait_fs("auto_adv", p, auto_seq[k]);
            p = auto_seq[k];
        end

        // Next press in the frame where the auto counter is at its terminal value.
        wait_fs("sim_c1", 4'd6, 4'd6);
        wait_fs("sim_c2", 4'd6, 4'd6);
        press(1'b0);
        chk("sim_hold", {28'd0, bus.o_Pattern}, 32'd6);
        wait_fs("sim_adv", 4'd6, 4'd1);
        wait_fs("sim_r1", 4'd1, 4'd1);
        wait_fs("sim_r2", 4'd1, 4'd1);
        wait_fs("sim_restart", 4'd1, 4'd2);

        // Held-zero counts with a step pending: one pulse, one advance.
        press(1'b0);
        bus.i_Col_Count = 10'd0;
        bus.i_Row_Count = 10'd0;
        hold_zero = 1'b1;
        n_fs = 0;
        repeat (5) begin
            tick();
            if (bus.o_Frame_Start === 1'b1) n_fs++;
        end
        hold_zero = 1'b0;
        repeat (3) begin
            tick();
            if (bus.o_Frame_Start === 1'b1) n_fs++;
        end
        chk("fd_pulses", n_fs, 32'd1);
        chk("fd_pattern", {28'd0, bus.o_Pattern}, 32'd3);
        wait_fs("fd_after", 4'd3, 4'd3);
        chk("fd_auto", {31'd0, bus.o_Auto}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
